rtc_pps_trig: RTL and testbench

//  Time-event generator sitting directly downstream of the rtc: consumes its

---
 rtl/rtc_pps_trig_if.sv | 29 ++
 rtl/rtc_pps_trig.sv | 177 +++++++++++++++++
 tb/tb_rtc_pps_trig.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_pps_trig_if.sv
// Bus bundle between the rtc time source / register block and rtc_pps_trig.
// The master side drives rtc time and host controls; the slave side
// (rtc_pps_trig) returns the pps/trigger pulses and status.
interface rtc_pps_trig_if;
  logic [37:0] time_reg_ns_in;   // [37:8] integer ns, [7:0] fraction
  logic [47:0] time_reg_sec_in;
  logic        pps_en;
  logic        trig_ld;
  logic        trig_cancel;
  logic [47:0] trig_sec_in;
  logic [29:0] trig_ns_in;
  logic        pps_out;
  logic        trig_out;
  logic        trig_armed;
  logic        trig_done;
  logic        trig_late;

  modport master (
    output time_reg_ns_in, time_reg_sec_in, pps_en,
    output trig_ld, trig_cancel, trig_sec_in, trig_ns_in,
    input  pps_out, trig_out, trig_armed, trig_done, trig_late
  );

  modport slave (
    input  time_reg_ns_in, time_reg_sec_in, pps_en,
    input  trig_ld, trig_cancel, trig_sec_in, trig_ns_in,
    output pps_out, trig_out, trig_armed, trig_done, trig_late
  );
endinterface

// File: rtl/rtc_pps_trig.sv
// rtc_pps_trig: pulse-per-second and one-shot time trigger generator.
// The rtc time is registered once (S1); a second register (S2) of the
// seconds field detects any seconds change, which (re)starts the pps pulse.
// A three-state trigger FSM compares the registered time against a
// host-programmed target and emits a fixed-width pulse when it is reached.
module rtc_pps_trig #(
  parameter int unsigned PPS_WIDTH_CYC  = 12500000,
  parameter int unsigned TRIG_WIDTH_CYC = 8,
  parameter int unsigned CNT_W          = 24
) (
  input logic         clk,
  input logic         rst,
  rtc_pps_trig_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PULSE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PPS_LOAD  = CNT_W'(PPS_WIDTH_CYC);
  localparam logic [CNT_W-1:0] TRIG_LOAD = CNT_W'(TRIG_WIDTH_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Registered time (S1) and previous seconds (S2)
  logic [47:0] sec_q_reg;
  logic [29:0] ns_q_reg;
  logic [47:0] sec_prev_reg;
  logic        sample_vld_reg;
  logic        prev_vld_reg;

  // Pulse counters
  logic [CNT_W-1:0] pps_cnt_reg;
  logic [CNT_W-1:0] trig_cnt_reg;

  // Trigger target and status
  logic [47:0] tgt_sec_reg;
  logic [29:0] tgt_ns_reg;
  logic        first_cmp_reg;
  logic        done_reg;
  logic        late_reg;

  state_t state_reg;
  state_t state_next;

  logic rollover;
  logic cmp_hit;
  logic fire;
  logic trig_out_c;
  logic trig_armed_c;
  logic pure_ld;

  // The fractional ns bits carry no meaning for comparison or pps.
  logic [7:0] ns_frac_unused;
  assign ns_frac_unused = bus.time_reg_ns_in[7:0];

  // Capture rtc time every cycle; valid flags suppress a pps on the first sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q_reg      <= '0;
      ns_q_reg       <= '0;
      sec_prev_reg   <= '0;
      sample_vld_reg <= 1'b0;
      prev_vld_reg   <= 1'b0;
    end else begin
      sec_q_reg      <= bus.time_reg_sec_in;
      ns_q_reg       <= bus.time_reg_ns_in[37:8];
      sec_prev_reg   <= sec_q_reg;
      sample_vld_reg <= 1'b1;
      prev_vld_reg   <= sample_vld_reg;
    end
  end

  // Any change of the seconds field is a rollover, including loads and backward steps.
  assign rollover = prev_vld_reg && (sec_q_reg != sec_prev_reg);

  // Unsigned compare of the composite 78-bit time against the target.
  assign cmp_hit = {sec_q_reg, ns_q_reg} >= {tgt_sec_reg, tgt_ns_reg};

  // pps width counter: rollover (re)loads, disable clears immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      pps_cnt_reg <= '0;
    end else if (!bus.pps_en) begin
      pps_cnt_reg <= '0;
    end else if (rollover) begin
      pps_cnt_reg <= PPS_LOAD;
    end else if (pps_cnt_reg != '0) begin
      pps_cnt_reg <= pps_cnt_reg - CNT_ONE;
    end
  end

  assign bus.pps_out = (pps_cnt_reg != '0);

  // Trigger FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Trigger FSM next state: cancel beats load, load beats compare/countdown.
  always_comb begin
    state_next = state_reg;
    if (bus.trig_cancel) begin
      state_next = ST_IDLE;
    end else if (bus.trig_ld) begin
      state_next = ST_ARMED;
    end else begin
      case (state_reg)
        ST_ARMED: if (cmp_hit) state_next = ST_PULSE;
        ST_PULSE: if (trig_cnt_reg == CNT_ONE) state_next = ST_IDLE;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Trigger FSM outputs, decoded from the current state only.
  always_comb begin
    trig_out_c   = 1'b0;
    trig_armed_c = 1'b0;
    case (state_reg)
      ST_ARMED: trig_armed_c = 1'b1;
      ST_PULSE: trig_out_c   = 1'b1;
      default:  ;
    endcase
  end

  assign fire    = (state_reg == ST_ARMED) && (state_next == ST_PULSE);
  assign pure_ld = bus.trig_ld && !bus.trig_cancel;

  // Target latch, first-compare tracking, sticky flags and pulse countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt_sec_reg   <= '0;
      tgt_ns_reg    <= '0;
      first_cmp_reg <= 1'b0;
      done_reg      <= 1'b0;
      late_reg      <= 1'b0;
      trig_cnt_reg  <= '0;
    end else begin
      // The target is latched even when a simultaneous cancel wins.
      if (bus.trig_ld) begin
        tgt_sec_reg <= bus.trig_sec_in;
        tgt_ns_reg  <= bus.trig_ns_in;
      end

      if (pure_ld) begin
        done_reg      <= 1'b0;
        late_reg      <= 1'b0;
        first_cmp_reg <= 1'b1;
      end else if (fire) begin
        done_reg      <= 1'b1;
        first_cmp_reg <= 1'b0;
        // Target already behind us on the very first look after arming.
        if (first_cmp_reg) late_reg <= 1'b1;
      end else if (state_reg == ST_ARMED && !cmp_hit) begin
        first_cmp_reg <= 1'b0;
      end

      if (fire) begin
        trig_cnt_reg <= TRIG_LOAD;
      end else if (state_reg == ST_PULSE) begin
        trig_cnt_reg <= trig_cnt_reg - CNT_ONE;
      end
    end
  end

  assign bus.trig_out   = trig_out_c;
  assign bus.trig_armed = trig_armed_c;
  assign bus.trig_done  = done_reg;
  assign bus.trig_late  = late_reg;

endmodule

// File: tb/tb_rtc_pps_trig.sv
// Bench for rtc_pps_trig: directed scenarios followed by random time/control
// traffic. Every cycle the outputs are compared against an event-history
// reference model (rollovers, arm/cancel events and the first cycle the
// registered time meets the target).
module tb_rtc_pps_trig;
  localparam int PPS_W  = 4;
  localparam int TRIG_W = 8;
  localparam int MAXC   = 4096;
  localparam int unsigned NS_MAX = 999_999_999;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rtc_pps_trig_if bus ();

  rtc_pps_trig #(
    .PPS_WIDTH_CYC (PPS_W),
    .TRIG_WIDTH_CYC(TRIG_W),
    .CNT_W         (24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Per-cycle log of what was applied (cycle 0 = first cycle out of reset)
  logic [47:0] sec_log [MAXC];
  logic [77:0] t_log   [MAXC];
  logic [77:0] tgt_log [MAXC];
  bit          en_log  [MAXC];
  bit          ld_log  [MAXC];
  bit          cn_log  [MAXC];

  int cyc   = -1;
  int n_cmp = 0;
  int n_bad = 0;

  // Values to drive in the next cycle
  logic [47:0] d_sec  = '0;
  logic [29:0] d_ns   = '0;
  logic        d_en   = 1'b0;
  logic        d_ld   = 1'b0;
  logic        d_cn   = 1'b0;
  logic [47:0] d_tsec = '0;
  logic [29:0] d_tns  = '0;

  task automatic chk(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  // pps is high at t when the latest seconds change (seen in input cycle j)
  // is recent enough and pps_en stayed high from the cycle it was noticed.
  function automatic logic exp_pps(input int t);
    int j;
    int lo;
    j  = -1;
    lo = (t - 1 - PPS_W < 1) ? 1 : t - 1 - PPS_W;
    for (int k = t - 2; k >= lo; k--) begin
      if (sec_log[k] != sec_log[k-1]) begin
        j = k;
        break;
      end
    end
    if (j < 0) return 1'b0;
    for (int k = j + 1; k <= t - 1; k++) begin
      if (!en_log[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // First cycle after the arm in cycle l where the registered time
  // (input of the previous cycle) meets the target, before any other event.
  function automatic int find_fire(input int l, input int t);
    for (int c = l + 1; c <= t - 1; c++) begin
      if (ld_log[c] || cn_log[c]) return -1;
      if (t_log[c-1] >= tgt_log[l]) return c;
    end
    return -1;
  endfunction

  task automatic exp_trig(input int t, output logic e_out, output logic e_arm,
                          output logic e_done, output logic e_late);
    int l;
    int lp;
    int f;
    e_out = 1'b0; e_arm = 1'b0; e_done = 1'b0; e_late = 1'b0;
    l = -1;
    for (int k = t - 1; k >= 0; k--) begin
      if (ld_log[k] || cn_log[k]) begin l = k; break; end
    end
    if (l >= 0 && ld_log[l] && !cn_log[l]) begin
      f = find_fire(l, t);
      if (f < 0) e_arm = 1'b1;
      else if (t <= f + TRIG_W) e_out = 1'b1;
    end
    lp = -1;
    for (int k = t - 1; k >= 0; k--) begin
      if (ld_log[k] && !cn_log[k]) begin lp = k; break; end
    end
    if (lp >= 0) begin
      f = find_fire(lp, t);
      if (f >= 0) begin
        e_done = 1'b1;
        e_late = (f == lp + 1);
      end
    end
  endtask

  task automatic check_cycle();
    logic e_out, e_arm, e_done, e_late;
    exp_trig(cyc, e_out, e_arm, e_done, e_late);
    chk("pps_out", bus.pps_out, exp_pps(cyc));
    chk("trig_out", bus.trig_out, e_out);
    chk("trig_armed", bus.trig_armed, e_arm);
    chk("trig_done", bus.trig_done, e_done);
    chk("trig_late", bus.trig_late, e_late);
  endtask

  task automatic drive();
    if (cyc >= MAXC) begin
      $display("FAIL log_overflow cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "log overflow");
    end
    bus.time_reg_sec_in = d_sec;
    bus.time_reg_ns_in  = {d_ns, 8'($urandom)};
    bus.pps_en          = d_en;
    bus.trig_ld         = d_ld;
    bus.trig_cancel     = d_cn;
    bus.trig_sec_in     = d_tsec;
    bus.trig_ns_in      = d_tns;
    sec_log[cyc] = d_sec;
    t_log[cyc]   = {d_sec, d_ns};
    tgt_log[cyc] = {d_tsec, d_tns};
    en_log[cyc]  = d_en;
    ld_log[cyc]  = d_ld;
    cn_log[cyc]  = d_cn;
    d_ld = 1'b0;
    d_cn = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
    drive();
  endtask

  task automatic adv(input longint unsigned step);
    longint unsigned tot;
    tot = 64'(d_ns) + step;
    while (tot > 64'(NS_MAX)) begin
      tot -= 64'd1_000_000_000;
      d_sec++;
    end
    d_ns = 30'(tot);
  endtask

  initial begin
    int n0;
    int r;

    // T1: reset held 3 cycles with toggling stimulus
    bus.time_reg_sec_in = 48'($urandom);
    bus.time_reg_ns_in  = 38'($urandom);
    bus.pps_en = 1'b1; bus.trig_ld = 1'b1; bus.trig_cancel = 1'b0;
    bus.trig_sec_in = '0; bus.trig_ns_in = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_pps_out", bus.pps_out, 1'b0);
      chk("rst_trig_out", bus.trig_out, 1'b0);
      chk("rst_trig_armed", bus.trig_armed, 1'b0);
      chk("rst_trig_done", bus.trig_done, 1'b0);
      chk("rst_trig_late", bus.trig_late, 1'b0);
      bus.time_reg_sec_in = 48'($urandom);
      bus.time_reg_ns_in  = 38'($urandom);
      bus.pps_en      = 1'($urandom);
      bus.trig_ld     = 1'($urandom);
      bus.trig_cancel = 1'($urandom);
      bus.trig_sec_in = 48'($urandom);
    end
    rst = 1'b0;
    cyc = 0;
    d_sec = 48'd5; d_ns = 30'd100; d_en = 1'b1;
    check_cycle();
    drive();
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t1_no_pps", bus.pps_out, 1'b0);
    end

    // T2: sec 5 -> 6, pps high N+2..N+5
    d_sec = 48'd6;
    tick();
    n0 = cyc;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t2_pps", bus.pps_out, (cyc - n0 >= 2) && (cyc - n0 <= 5));
    end

    // T3: arm 7 s / 500 ns, time walks 480 -> 500 ns
    d_sec = 48'd7; d_ns = 30'd480;
    repeat (6) tick();
    d_ld = 1'b1; d_tsec = 48'd7; d_tns = 30'd500;
    tick();
    d_ns = 30'd490;
    tick();
    chk("t3_armed_wait", bus.trig_armed, 1'b1);
    d_ns = 30'd500;
    tick();
    n0 = cyc;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t3_trig", bus.trig_out, (cyc - n0 >= 2) && (cyc - n0 <= 9));
    end
    chk("t3_done", bus.trig_done, 1'b1);
    chk("t3_late", bus.trig_late, 1'b0);
    chk("t3_armed", bus.trig_armed, 1'b0);

    // T4: late arm, target already behind
    d_sec = 48'd9; d_ns = 30'd0;
    repeat (6) tick();
    d_ld = 1'b1; d_tsec = 48'd8; d_tns = 30'd999_999_999;
    tick();
    tick();
    chk("t4_armed", bus.trig_armed, 1'b1);
    chk("t4_done_cleared", bus.trig_done, 1'b0);
    tick();
    chk("t4_trig", bus.trig_out, 1'b1);
    chk("t4_late", bus.trig_late, 1'b1);
    chk("t4_done", bus.trig_done, 1'b1);
    repeat (10) tick();

    // T5: cancel before 10 s, then re-arm in the middle of a pulse
    d_ns = 30'd500_000_000;
    repeat (2) tick();
    d_ld = 1'b1; d_tsec = 48'd10; d_tns = 30'd0;
    tick();
    adv(100_000_000); tick();
    adv(100_000_000); tick();
    d_cn = 1'b1; adv(100_000_000); tick();
    tick();
    chk("t5_cancel_armed", bus.trig_armed, 1'b0);
    for (int k = 0; k < 6; k++) begin
      adv(100_000_000);
      tick();
      chk("t5_no_trig", bus.trig_out, 1'b0);
    end
    d_sec = 48'd11; d_ns = 30'd900_000_000;
    repeat (3) tick();
    d_ld = 1'b1; d_tsec = 48'd12; d_tns = 30'd0;
    tick();
    d_sec = 48'd12; d_ns = 30'd0;
    tick();
    tick();
    tick();
    chk("t5_pulse", bus.trig_out, 1'b1);
    tick();
    d_ld = 1'b1; d_tsec = 48'd20; d_tns = 30'd0;
    tick();
    chk("t5_pulse_before_rearm", bus.trig_out, 1'b1);
    tick();
    chk("t5_rearm_drop", bus.trig_out, 1'b0);
    chk("t5_rearm_armed", bus.trig_armed, 1'b1);
    d_sec = 48'd19; d_ns = 30'd950_000_000;
    repeat (4) tick();
    d_sec = 48'd20; d_ns = 30'd0;
    tick();
    n0 = cyc;
    tick();
    chk("t5_fire20_early", bus.trig_out, 1'b0);
    tick();
    chk("t5_fire20", bus.trig_out, 1'b1);
    repeat (10) tick();

    // T6: armed for 3 s, time loaded back from 2.9 s to 1.0 s
    d_sec = 48'd2; d_ns = 30'd900_000_000;
    repeat (6) tick();
    d_ld = 1'b1; d_tsec = 48'd3; d_tns = 30'd0;
    tick();
    repeat (2) tick();
    d_sec = 48'd1; d_ns = 30'd0;
    tick();
    tick();
    tick();
    chk("t6_load_pps", bus.pps_out, 1'b1);
    chk("t6_armed", bus.trig_armed, 1'b1);
    for (int k = 0; k < 8; k++) begin
      adv(250_000_000);
      tick();
      chk("t6_no_fire", bus.trig_out, 1'b0);
    end
    tick();
    chk("t6_no_fire_n1", bus.trig_out, 1'b0);
    tick();
    chk("t6_fire", bus.trig_out, 1'b1);
    chk("t6_late", bus.trig_late, 1'b0);
    repeat (10) tick();

    // Random traffic: time runs, jumps and steps back; random arms/cancels
    d_sec = 48'd1000;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        d_sec = d_sec - 48'($urandom_range(0, 2));
        d_ns  = 30'($urandom_range(0, NS_MAX));
      end else if (r < 5) begin
        d_sec = d_sec + 48'($urandom_range(1, 3));
      end else begin
        adv(64'($urandom_range(0, 300_000_000)));
      end
      if ($urandom_range(0, 99) < 2) d_en = ~d_en;
      if ($urandom_range(0, 99) < 5) begin
        d_ld = 1'b1;
        case ($urandom_range(0, 3))
          0:       d_tsec = d_sec - 48'd1;
          1:       d_tsec = d_sec;
          default: d_tsec = d_sec + 48'($urandom_range(0, 1));
        endcase
        d_tns = 30'($urandom_range(0, NS_MAX));
      end
      if ($urandom_range(0, 99) < 2) d_cn = 1'b1;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
